// File: rtl/simd_wave_sequencer.sv
// Per-SIMD-unit wave sequencer: steps one wave through fetch/decode/RF/ALU/memory lane groups.
// Optional stall-cycle counter built when SIMD_STALL_CNT_EN is defined.
module simd_wave_sequencer #(
  parameter  int unsigned WAVE_SIZE       = 32,
  parameter  int unsigned LANE_WIDTH      = 16,
  localparam int unsigned NUM_WAVE_CYCLES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH,
  localparam int unsigned CYCLE_W         = (NUM_WAVE_CYCLES > 1) ? $clog2(NUM_WAVE_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               fetch_valid,
  input  logic               dec_reg_write,
  input  logic               dec_mem_op,
  input  logic               dec_ret,
  input  logic               mem_ready,
  output logic [2:0]         simd_state,
  output logic [CYCLE_W-1:0] curr_wave_cycle,
  output logic               rf_enable,
  output logic               rf_reg_write,
  output logic               fetch_req,
  output logic               mem_req,
  output logic               pc_advance,
  output logic               wave_done
`ifdef SIMD_STALL_CNT_EN
  ,
  input  logic               stall_clr,
  output logic [31:0]        stall_cycles
`endif
);

  localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(NUM_WAVE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_e;

  state_e               state_q, state_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_op_q, mem_op_d;
  logic                 ret_q, ret_d;
  logic                 rf_enable_q, rf_enable_d;
  logic                 rf_reg_write_q, rf_reg_write_d;
  logic                 fetch_req_q, fetch_req_d;
  logic                 mem_req_q, mem_req_d;
  logic                 pc_advance_q, pc_advance_d;
  logic                 wave_done_q, wave_done_d;

  // Next state, lane-group index and decode-flag capture; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    reg_write_d = reg_write_q;
    mem_op_d    = mem_op_q;
    ret_d       = ret_q;

    unique case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_valid) begin
          reg_write_d = dec_reg_write;
          mem_op_d    = dec_mem_op;
          ret_d       = dec_ret;
          state_d     = S_DECODE;
        end
      end
      S_DECODE:  state_d = ret_q ? S_DONE : S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    if (!mem_op_q || mem_ready) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        if (cycle_q == LAST_CYCLE) begin
          cycle_d = '0;
          state_d = S_FETCH;
        end else begin
          cycle_d = cycle_q + CYCLE_W'(1);
          state_d = S_REQUEST;
        end
      end
      S_DONE:    if (!start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cycle_d = '0;
    end
  end

  // Outputs are registered alongside the state so they line up with simd_state.
  always_comb begin
    rf_enable_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    fetch_req_d    = (state_d == S_FETCH);
    mem_req_d      = (state_d == S_WAIT) && mem_op_d;
    rf_reg_write_d = (state_d == S_UPDATE) && reg_write_d;
    pc_advance_d   = (state_d == S_UPDATE) && (cycle_d == LAST_CYCLE);
    wave_done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cycle_q        <= '0;
      reg_write_q    <= 1'b0;
      mem_op_q       <= 1'b0;
      ret_q          <= 1'b0;
      rf_enable_q    <= 1'b0;
      rf_reg_write_q <= 1'b0;
      fetch_req_q    <= 1'b0;
      mem_req_q      <= 1'b0;
      pc_advance_q   <= 1'b0;
      wave_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycle_q        <= cycle_d;
      reg_write_q    <= reg_write_d;
      mem_op_q       <= mem_op_d;
      ret_q          <= ret_d;
      rf_enable_q    <= rf_enable_d;
      rf_reg_write_q <= rf_reg_write_d;
      fetch_req_q    <= fetch_req_d;
      mem_req_q      <= mem_req_d;
      pc_advance_q   <= pc_advance_d;
      wave_done_q    <= wave_done_d;
    end
  end

  assign simd_state      = state_q;
  assign curr_wave_cycle = cycle_q;
  assign rf_enable       = rf_enable_q;
  assign rf_reg_write    = rf_reg_write_q;
  assign fetch_req       = fetch_req_q;
  assign mem_req         = mem_req_q;
  assign pc_advance      = pc_advance_q;
  assign wave_done       = wave_done_q;

`ifdef SIMD_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_c;

  // Saturating count of cycles spent waiting on the fetcher or memory; clear wins.
  always_comb begin
    stall_c = ((state_q == S_FETCH) && !fetch_valid) ||
              ((state_q == S_WAIT) && mem_op_q && !mem_ready);
    stall_d = stall_q;
    if (stall_clr)                       stall_d = '0;
    else if (stall_c && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_simd_wave_sequencer.sv
// Directed self-checking bench for simd_wave_sequencer (default 32-thread wave, 16 lanes).
module tb_simd_wave_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, fetch_valid, dec_reg_write, dec_mem_op, dec_ret, mem_ready;
  logic [2:0] simd_state;
  logic [0:0] curr_wave_cycle;
  logic       rf_enable, rf_reg_write, fetch_req, mem_req, pc_advance, wave_done;
`ifdef SIMD_STALL_CNT_EN
  logic        stall_clr;
  logic [31:0] stall_cycles;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Output flag vectors {rf_enable, rf_reg_write, fetch_req, mem_req, pc_advance, wave_done}
  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_FETCH = 6'b101000;
  localparam logic [5:0] F_BUSY  = 6'b100000;
  localparam logic [5:0] F_MWAIT = 6'b100100;
  localparam logic [5:0] F_UPDW  = 6'b110000;
  localparam logic [5:0] F_UPDWP = 6'b110010;
  localparam logic [5:0] F_UPDP  = 6'b100010;
  localparam logic [5:0] F_DONE  = 6'b000001;

  simd_wave_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fetch_valid(fetch_valid),
    .dec_reg_write(dec_reg_write), .dec_mem_op(dec_mem_op), .dec_ret(dec_ret),
    .mem_ready(mem_ready), .simd_state(simd_state), .curr_wave_cycle(curr_wave_cycle),
    .rf_enable(rf_enable), .rf_reg_write(rf_reg_write), .fetch_req(fetch_req),
    .mem_req(mem_req), .pc_advance(pc_advance), .wave_done(wave_done)
`ifdef SIMD_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_o(input string tag, input logic [2:0] st, input logic cyc,
                          input logic [5:0] flags);
    check(tag, 32'({simd_state, curr_wave_cycle, rf_enable, rf_reg_write, fetch_req,
                    mem_req, pc_advance, wave_done}),
          32'({st, cyc, flags}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks REQUEST/WAIT/EXECUTE/UPDATE for one lane group of a non-memory op.
  task automatic alu_group(input string tag, input logic cyc, input logic [5:0] upd_flags);
    expect_o({tag, "_req"}, 3'b011, cyc, F_BUSY);  tick();
    expect_o({tag, "_wait"}, 3'b100, cyc, F_BUSY); tick();
    expect_o({tag, "_exe"}, 3'b101, cyc, F_BUSY);  tick();
    expect_o({tag, "_upd"}, 3'b110, cyc, upd_flags); tick();
  endtask

  // Fetch an instruction from FETCH state with immediate fetch_valid.
  task automatic issue(input logic rw, input logic mo, input logic rt);
    fetch_valid = 1'b1; dec_reg_write = rw; dec_mem_op = mo; dec_ret = rt;
    tick();
    fetch_valid = 1'b0; dec_reg_write = 1'b0; dec_mem_op = 1'b0; dec_ret = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; fetch_valid = 1'b0;
    dec_reg_write = 1'b0; dec_mem_op = 1'b0; dec_ret = 1'b0; mem_ready = 1'b0;
`ifdef SIMD_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    tick(); tick();
    expect_o("reset", 3'b000, 1'b0, F_IDLE);
    rst = 1'b1;
    tick();
    expect_o("idle_no_start", 3'b000, 1'b0, F_IDLE);

    // 1: ALU op with register write, two lane groups
    start = 1'b1; tick(); start = 1'b0;
    expect_o("t1_fetch", 3'b001, 1'b0, F_FETCH);
    issue(1'b1, 1'b0, 1'b0);
    expect_o("t1_decode", 3'b010, 1'b0, F_BUSY); tick();
    alu_group("t1_g0", 1'b0, F_UPDW);
    alu_group("t1_g1", 1'b1, F_UPDWP);
    expect_o("t1_refetch", 3'b001, 1'b0, F_FETCH);
`ifdef SIMD_STALL_CNT_EN
    check("t1_stall", stall_cycles, 32'd0);
`endif

    // 2: store, mem_ready three cycles late per lane group
    issue(1'b0, 1'b1, 1'b0);
    expect_o("t2_decode", 3'b010, 1'b0, F_BUSY); tick();
    for (int g = 0; g < 2; g++) begin
      expect_o("t2_req", 3'b011, 1'(g), F_BUSY); tick();
      for (int k = 0; k < 4; k++) begin
        expect_o("t2_wait", 3'b100, 1'(g), F_MWAIT);
        mem_ready = (k == 3);
        tick();
      end
      mem_ready = 1'b0;
      expect_o("t2_exe", 3'b101, 1'(g), F_BUSY); tick();
      expect_o("t2_upd", 3'b110, 1'(g), (g == 1) ? F_UPDP : F_BUSY); tick();
    end
    expect_o("t2_refetch", 3'b001, 1'b0, F_FETCH);
`ifdef SIMD_STALL_CNT_EN
    check("t2_stall", stall_cycles, 32'd6);
`endif

    // 3: fetch_valid withheld 5 cycles, then ret; start held through DONE
    for (int k = 0; k < 6; k++) begin
      expect_o("t3_fetch_hold", 3'b001, 1'b0, F_FETCH);
      if (k == 5) begin
        fetch_valid = 1'b1; dec_ret = 1'b1;
      end
      tick();
    end
    fetch_valid = 1'b0; dec_ret = 1'b0; start = 1'b1;
    expect_o("t3_decode", 3'b010, 1'b0, F_BUSY); tick();
    expect_o("t3_done", 3'b111, 1'b0, F_DONE); tick();
    expect_o("t3_done_hold", 3'b111, 1'b0, F_DONE);
    start = 1'b0; tick();
    expect_o("t3_idle", 3'b000, 1'b0, F_IDLE);
`ifdef SIMD_STALL_CNT_EN
    check("t3_stall", stall_cycles, 32'd11);
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    check("t3_stall_clr", stall_cycles, 32'd0);
`endif

    // 4: abort in the second EXECUTE
    start = 1'b1; tick(); start = 1'b0;
    issue(1'b1, 1'b0, 1'b0);
    tick();
    alu_group("t4_g0", 1'b0, F_UPDW);
    expect_o("t4_req1", 3'b011, 1'b1, F_BUSY); tick();
    expect_o("t4_wait1", 3'b100, 1'b1, F_BUSY); tick();
    expect_o("t4_exe1", 3'b101, 1'b1, F_BUSY);
    abort = 1'b1; tick(); abort = 1'b0;
    expect_o("t4_abort", 3'b000, 1'b0, F_IDLE); tick();
    expect_o("t4_stay_idle", 3'b000, 1'b0, F_IDLE);

    // 6: start pulse during EXECUTE is ignored
    start = 1'b1; tick(); start = 1'b0;
    issue(1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    expect_o("t6_exe", 3'b101, 1'b0, F_BUSY);
    start = 1'b1; tick(); start = 1'b0;
    expect_o("t6_upd0", 3'b110, 1'b0, F_UPDW); tick();
    alu_group("t6_g1", 1'b1, F_UPDWP);
    expect_o("t6_refetch", 3'b001, 1'b0, F_FETCH);

    // 5: asynchronous reset mid-WAIT
    issue(1'b0, 1'b1, 1'b0);
    tick(); tick();
    expect_o("t5_wait", 3'b100, 1'b0, F_MWAIT);
    #2 rst = 1'b0;
    #1 expect_o("t5_async_rst", 3'b000, 1'b0, F_IDLE);
    tick();
    #2 rst = 1'b1;
    tick(); tick(); tick();
    expect_o("t5_idle_after", 3'b000, 1'b0, F_IDLE);
    start = 1'b1; tick(); start = 1'b0;
    expect_o("t5_restart", 3'b001, 1'b0, F_FETCH);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
